// File: rtl/cu_dcdr_pipe_if.sv
// Handshake and control-bundle signals between the IF/ID register, the decode stage and EX.
// master = surrounding pipeline (drives instr/flush/out_ready), slave = the decode stage.
interface cu_dcdr_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_fun;
  logic [1:0]  alu_srcA;
  logic [2:0]  alu_srcB;
  logic [1:0]  rf_wr_sel;
  logic        regWrite;
  logic        memWrite;
  logic        memRead2;
  logic        csr_WE;
  logic        mret_exec;
  logic [2:0]  mdu_op;
  logic        mdu_sel;
  logic        mdu_start;
  logic        mdu_abort;
  logic        illegal;

  modport master (
    output in_valid, instr, flush, out_ready,
    input  in_ready, out_valid, alu_fun, alu_srcA, alu_srcB, rf_wr_sel, regWrite,
           memWrite, memRead2, csr_WE, mret_exec, mdu_op, mdu_sel, mdu_start,
           mdu_abort, illegal
  );

  modport slave (
    input  in_valid, instr, flush, out_ready,
    output in_ready, out_valid, alu_fun, alu_srcA, alu_srcB, rf_wr_sel, regWrite,
           memWrite, memRead2, csr_WE, mret_exec, mdu_op, mdu_sel, mdu_start,
           mdu_abort, illegal
  );
endinterface

// File: rtl/cu_dcdr_pipe.sv
// Registered OTTER control-unit decoder with valid/ready handshakes, flush and illegal flagging.
// Define OTTER_MEXT_EN to enable RV32M decode and the multi-cycle MDU wait state.
module cu_dcdr_pipe #(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 34
) (
  input logic           CLK,
  input logic           RST,
  cu_dcdr_pipe_if.slave io
);
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

`ifdef OTTER_MEXT_EN
  localparam bit MEXT_EN = 1'b1;
`else
  localparam bit MEXT_EN = 1'b0;
`endif

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  typedef enum logic {S_RUN, S_MDU_BUSY} state_t;

  typedef struct packed {
    logic [3:0] alu_fun;
    logic [1:0] alu_srcA;
    logic [2:0] alu_srcB;
    logic [1:0] rf_wr_sel;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read2;
    logic       csr_we;
    logic       mret_exec;
    logic [2:0] mdu_op;
    logic       mdu_sel;
    logic       illegal;
  } bundle_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lat_m1;
  bundle_t          dec;
  bundle_t          bundle;
  logic             out_valid;
  logic             mdu_start;
  logic             mdu_abort;
  logic             accept;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode = io.instr[6:0];
  assign f3     = io.instr[14:12];
  assign f7     = io.instr[31:25];

  always_comb begin
    // NOTE: every field gets a default first, so no path through the case infers a latch.
    dec = '0;
    case (opcode)
      OP_R: begin
        if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
          dec.alu_fun   = {f7[5], f3};
          dec.rf_wr_sel = 2'd3;
          dec.reg_write = 1'b1;
        end else if (MEXT_EN && f7 == 7'b0000001) begin
          dec.mdu_sel   = 1'b1;
          dec.mdu_op    = f3;
          dec.rf_wr_sel = 2'd3;
          dec.reg_write = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_IMM: begin
        dec.alu_srcB = 3'd1;
        dec.alu_fun  = (f3 == 3'b101) ? {f7[5], f3} : {1'b0, f3};
      end
      OP_LOAD: begin
        dec.alu_srcB  = 3'd1;
        dec.mem_read2 = 1'b1;
        dec.rf_wr_sel = 2'd2;
        dec.reg_write = 1'b1;
      end
      OP_STORE: begin
        dec.alu_srcB  = 3'd2;
        dec.mem_write = 1'b1;
      end
      OP_LUI: begin
        dec.alu_srcA  = 2'd1;
        dec.alu_fun   = 4'b1001;
        dec.rf_wr_sel = 2'd3;
        dec.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        dec.alu_srcA  = 2'd1;
        dec.alu_srcB  = 3'd3;
        dec.rf_wr_sel = 2'd3;
        dec.reg_write = 1'b1;
      end
      OP_JAL, OP_JALR: dec.reg_write = 1'b1;
      OP_BRANCH: ;
      OP_SYS: begin
        // CSRRW/CSRRS/CSRRC share the write path and differ only in ALU setup.
        case (f3)
          3'b000: dec.mret_exec = 1'b1;
          3'b001, 3'b010, 3'b011: begin
            dec.csr_we    = 1'b1;
            dec.reg_write = 1'b1;
            dec.rf_wr_sel = 2'd1;
            dec.alu_fun   = (f3 == 3'b001) ? 4'b1001 : (f3 == 3'b010) ? 4'b0110 : 4'b0111;
            dec.alu_srcB  = (f3 == 3'b001) ? 3'd0 : 3'd4;
            dec.alu_srcA  = (f3 == 3'b011) ? 2'd2 : 2'd0;
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  assign lat_m1 = dec.mdu_op[2] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);

  // Reset is folded in so in_ready reads 0 alongside every registered output while RST is high.
  assign io.in_ready = !RST && (state == S_RUN) && (!out_valid || io.out_ready) && !io.flush;
  assign accept      = io.in_valid && io.in_ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_RUN;
      cnt       <= '0;
      bundle    <= '0;
      out_valid <= 1'b0;
      mdu_start <= 1'b0;
      mdu_abort <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      mdu_start <= 1'b0;
      mdu_abort <= 1'b0;
      if (io.flush) begin
        out_valid <= 1'b0;
        state     <= S_RUN;
        cnt       <= '0;
        mdu_abort <= (state == S_MDU_BUSY);
      end else begin
        case (state)
          S_RUN: begin
            if (accept) begin
              bundle <= dec;
              if (dec.mdu_sel) begin
                state     <= S_MDU_BUSY;
                cnt       <= lat_m1;
                mdu_start <= 1'b1;
                out_valid <= 1'b0;
              end else begin
                out_valid <= 1'b1;
              end
            end else if (io.out_ready) begin
              out_valid <= 1'b0;
            end
          end
          S_MDU_BUSY: begin
            if (cnt == '0) begin
              out_valid <= 1'b1;
              state     <= S_RUN;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: state <= S_RUN;
        endcase
      end
    end
  end

  assign io.out_valid = out_valid;
  assign io.alu_fun   = bundle.alu_fun;
  assign io.alu_srcA  = bundle.alu_srcA;
  assign io.alu_srcB  = bundle.alu_srcB;
  assign io.rf_wr_sel = bundle.rf_wr_sel;
  assign io.regWrite  = bundle.reg_write;
  assign io.memWrite  = bundle.mem_write;
  assign io.memRead2  = bundle.mem_read2;
  assign io.csr_WE    = bundle.csr_we;
  assign io.mret_exec = bundle.mret_exec;
  assign io.mdu_op    = bundle.mdu_op;
  assign io.mdu_sel   = bundle.mdu_sel;
  assign io.mdu_start = mdu_start;
  assign io.mdu_abort = mdu_abort;
  assign io.illegal   = bundle.illegal;
endmodule

// File: tb/tb_cu_dcdr_pipe.sv
// Directed bench for cu_dcdr_pipe: decode table, handshake, flush, reset; MDU waits when OTTER_MEXT_EN.
module tb_cu_dcdr_pipe;
  logic CLK = 1'b0;
  logic RST;

  cu_dcdr_pipe_if io();

  cu_dcdr_pipe #(.MUL_LAT(2), .DIV_LAT(34)) dut (
    .CLK (CLK),
    .RST (RST),
    .io  (io)
  );

  always #5 CLK = ~CLK;

  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_SUB = 32'h402081B3;
  localparam logic [31:0] I_MUL = 32'h022081B3;
  localparam logic [31:0] I_DIV = 32'h0220C1B3;

  int checks = 0;
  int errors = 0;

  // exp = {alu_fun, srcA, srcB, rf_wr_sel, regWrite, memWrite, memRead2, csr_WE, mret_exec, mdu_sel, illegal}
  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [17:0] bundle_now();
    return {io.alu_fun, io.alu_srcA, io.alu_srcB, io.rf_wr_sel, io.regWrite, io.memWrite,
            io.memRead2, io.csr_WE, io.mret_exec, io.mdu_sel, io.illegal};
  endfunction

  function automatic logic [24:0] all_out();
    return {io.in_ready, io.out_valid, bundle_now(), io.mdu_op, io.mdu_start, io.mdu_abort};
  endfunction

  function automatic vec_t mk(input string n, input logic [31:0] i, input logic [3:0] alu,
                              input logic [1:0] a, input logic [2:0] b, input logic [1:0] sel,
                              input logic [6:0] fl);
    vec_t v;
    v.name  = n;
    v.instr = i;
    v.exp   = {alu, a, b, sel, fl};
    return v;
  endfunction

`ifdef OTTER_MEXT_EN
  task automatic run_mop(input string n, input logic [31:0] ins, input int lat, input logic [2:0] op);
    int cyc;
    io.out_ready = 1'b1;
    io.flush     = 1'b0;
    io.instr     = ins;
    io.in_valid  = 1'b1;
    tick();
    io.in_valid = 1'b0;
    #1;
    check({n, "_start"}, 32'(io.mdu_start), 1);
    check({n, "_in_ready_busy"}, 32'(io.in_ready), 0);
    check({n, "_no_valid"}, 32'(io.out_valid), 0);
    tick();
    cyc = 1;
    check({n, "_start_pulse"}, 32'(io.mdu_start), 0);
    while (!io.out_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    check({n, "_latency"}, cyc, lat);
    check({n, "_bundle"}, 32'({io.mdu_sel, io.mdu_op, io.regWrite, io.rf_wr_sel, io.illegal}),
          32'({1'b1, op, 1'b1, 2'd3, 1'b0}));
    tick();
    check({n, "_drain"}, 32'(io.out_valid), 0);
  endtask
`endif

  initial begin
    int seen;
    RST          = 1'b1;
    io.in_valid  = 1'b0;
    io.instr     = '0;
    io.flush     = 1'b0;
    io.out_ready = 1'b0;

    vecs.push_back(mk("add",     I_ADD,        4'b0000, 2'd0, 3'd0, 2'd3, 7'b1000000));
    vecs.push_back(mk("sub",     I_SUB,        4'b1000, 2'd0, 3'd0, 2'd3, 7'b1000000));
    vecs.push_back(mk("or",      32'h0020E1B3, 4'b0110, 2'd0, 3'd0, 2'd3, 7'b1000000));
    vecs.push_back(mk("srai",    32'h4020D193, 4'b1101, 2'd0, 3'd1, 2'd0, 7'b0000000));
    vecs.push_back(mk("andi",    32'hFFF0F093, 4'b0111, 2'd0, 3'd1, 2'd0, 7'b0000000));
    vecs.push_back(mk("lw",      32'h0000A183, 4'b0000, 2'd0, 3'd1, 2'd2, 7'b1010000));
    vecs.push_back(mk("sw",      32'h0020A023, 4'b0000, 2'd0, 3'd2, 2'd0, 7'b0100000));
    vecs.push_back(mk("lui",     32'h123451B7, 4'b1001, 2'd1, 3'd0, 2'd3, 7'b1000000));
    vecs.push_back(mk("auipc",   32'h00001197, 4'b0000, 2'd1, 3'd3, 2'd3, 7'b1000000));
    vecs.push_back(mk("jal",     32'h000000EF, 4'b0000, 2'd0, 3'd0, 2'd0, 7'b1000000));
    vecs.push_back(mk("beq",     32'h00208063, 4'b0000, 2'd0, 3'd0, 2'd0, 7'b0000000));
    vecs.push_back(mk("jalr",    32'h000100E7, 4'b0000, 2'd0, 3'd0, 2'd0, 7'b1000000));
    vecs.push_back(mk("bad_op",  32'h0000007F, 4'b0000, 2'd0, 3'd0, 2'd0, 7'b0000001));
    vecs.push_back(mk("mret",    32'h30200073, 4'b0000, 2'd0, 3'd0, 2'd0, 7'b0000100));
    vecs.push_back(mk("sys_f3_4",32'h3000C1F3, 4'b0000, 2'd0, 3'd0, 2'd0, 7'b0000001));
    vecs.push_back(mk("csrrw",   32'h300091F3, 4'b1001, 2'd0, 3'd0, 2'd1, 7'b1001000));
    vecs.push_back(mk("r_f7_bad",32'h422081B3, 4'b0000, 2'd0, 3'd0, 2'd0, 7'b0000001));
    vecs.push_back(mk("csrrs",   32'h3000A1F3, 4'b0110, 2'd0, 3'd4, 2'd1, 7'b1001000));
    vecs.push_back(mk("csrrc",   32'h3000B1F3, 4'b0111, 2'd2, 3'd4, 2'd1, 7'b1001000));
`ifndef OTTER_MEXT_EN
    vecs.push_back(mk("mul_no_mext", I_MUL,    4'b0000, 2'd0, 3'd0, 2'd0, 7'b0000001));
`endif

    repeat (2) @(posedge CLK);
    #1;
    check("reset_outputs", 32'(all_out()), 0);
    RST = 1'b0;
    #1;
    check("ready_after_reset", 32'(io.in_ready), 1);

    // Back-to-back decode table: one accept per cycle, each bundle differs from its neighbour.
    io.out_ready = 1'b1;
    foreach (vecs[i]) begin
      io.instr    = vecs[i].instr;
      io.in_valid = 1'b1;
      tick();
      check({vecs[i].name, "_valid"}, 32'(io.out_valid), 1);
      check(vecs[i].name, 32'(bundle_now()), 32'(vecs[i].exp));
    end
    io.in_valid = 1'b0;
    tick();
    check("table_drain", 32'(io.out_valid), 0);

    // Backpressure: add held for 5 cycles while sub waits, then drains and sub enters same cycle.
    io.out_ready = 1'b0;
    io.instr     = I_ADD;
    io.in_valid  = 1'b1;
    tick();
    io.instr = I_SUB;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_in_ready", 32'(io.in_ready), 0);
      check("bp_hold", 32'({io.out_valid, bundle_now()}), 32'({1'b1, vecs[0].exp}));
      tick();
    end
    io.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(io.in_ready), 1);
    tick();
    check("bp_next", 32'({io.out_valid, bundle_now()}), 32'({1'b1, vecs[1].exp}));

    // Flush of a held base-op bundle: no accept in the flush cycle, no abort outside MDU wait.
    io.out_ready = 1'b0;
    io.instr     = I_ADD;
    io.in_valid  = 1'b1;
    io.flush     = 1'b1;
    #1;
    check("flush_in_ready", 32'(io.in_ready), 0);
    tick();
    io.flush    = 1'b0;
    io.in_valid = 1'b0;
    check("flush_valid", 32'(io.out_valid), 0);
    check("flush_no_abort", 32'(io.mdu_abort), 0);
    tick();
    check("flush_no_accept", 32'(io.out_valid), 0);

`ifdef OTTER_MEXT_EN
    run_mop("div", I_DIV, 34, 3'b100);
    run_mop("mul", I_MUL, 2, 3'b000);

    // Flush on cycle 10 of a DIV wait.
    io.instr    = I_DIV;
    io.in_valid = 1'b1;
    tick();
    io.in_valid = 1'b0;
    repeat (9) tick();
    io.flush = 1'b1;
    tick();
    io.flush = 1'b0;
    check("div_flush_abort", 32'(io.mdu_abort), 1);
    check("div_flush_valid", 32'(io.out_valid), 0);
    tick();
    check("div_abort_pulse", 32'(io.mdu_abort), 0);
    seen = 0;
    repeat (40) begin
      tick();
      if (io.out_valid) seen++;
    end
    check("div_flush_never_valid", seen, 0);
    check("div_flush_run", 32'(io.in_ready), 1);

    // Flush on the same edge the MUL counter expires.
    io.instr    = I_MUL;
    io.in_valid = 1'b1;
    tick();
    io.in_valid = 1'b0;
    tick();
    io.flush = 1'b1;
    tick();
    io.flush = 1'b0;
    check("mul_flush_abort", 32'(io.mdu_abort), 1);
    seen = 0;
    repeat (5) begin
      if (io.out_valid) seen++;
      tick();
    end
    check("mul_flush_never_valid", seen, 0);

    // Asynchronous reset in the middle of a DIV wait.
    io.instr    = I_DIV;
    io.in_valid = 1'b1;
    tick();
    io.in_valid = 1'b0;
    repeat (5) tick();
`else
    // Asynchronous reset while a bundle is held under backpressure.
    io.out_ready = 1'b0;
    io.instr     = I_ADD;
    io.in_valid  = 1'b1;
    tick();
    io.in_valid = 1'b0;
    tick();
`endif
    #2;
    RST = 1'b1;
    #1;
    check("async_reset_outputs", 32'(all_out()), 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    io.out_ready = 1'b1;
    #1;
    check("ready_after_async_reset", 32'(io.in_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/cu_dcdr_pipe.md
Name: cu_dcdr_pipe

Overview:
- Registered, parametrised successor to the OTTER control-unit decoder. Sits between the IF/ID and ID/EX pipeline registers of the 5-stage core.
- Decodes a full 32-bit instruction into the OTTER control bundle and holds it in an output register with valid/ready handshakes on both sides.
- Adds RV32M multiply/divide decode. M-ops hold the stage for a parametrised number of cycles while the multi-cycle MDU runs.
- Adds illegal-instruction flagging and pipeline flush.

Parameters:
MUL_LAT, 2, cycles from MDU start until the MUL/MULH/MULHSU/MULHU result is ready (>=1)
DIV_LAT, 34, cycles from MDU start until the DIV/DIVU/REM/REMU result is ready (>=1)
CNT_W, $clog2(max(MUL_LAT,DIV_LAT)+1), busy-counter width (derived, not overridable)

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
in_valid  in  1  IF/ID holds a valid instruction
in_ready  out  1  stage accepts the instruction this cycle
instr  in  32  instruction word; opcode=[6:0], funct3=[14:12], funct7=[31:25]
flush  in  1  kill the held instruction and any MDU wait (branch taken / trap)
out_valid  out  1  control bundle is valid for EX
out_ready  in  1  EX consumes the bundle
alu_fun  out  4  ALU op: add=0000, sub=1000, or=0110, and=0111, copyA=1001, otherwise {f7[5],f3}
alu_srcA  out  2  0=rs1, 1=U-imm, 2=~rs1
alu_srcB  out  3  0=rs2, 1=I-imm, 2=S-imm, 3=PC, 4=CSR
rf_wr_sel  out  2  0=PC+4, 1=CSR, 2=mem DOUT2, 3=ALU/MDU
regWrite  out  1  register-file write enable
memWrite  out  1  data-memory write
memRead2  out  1  data-memory read
csr_WE  out  1  CSR write
mret_exec  out  1  MRET
mdu_op  out  3  funct3 of the M-op; valid when mdu_sel=1
mdu_sel  out  1  writeback comes from the MDU instead of the ALU
mdu_start  out  1  one-cycle pulse that launches the MDU
mdu_abort  out  1  one-cycle pulse that cancels an in-flight MDU op
illegal  out  1  bundle is an illegal instruction; all write enables forced to 0

Behaviour:
- Reset: every output is 0 and the FSM is in RUN. Takes effect immediately (async), including in the middle of an MDU wait.
- Decode table, base ISA:
  - R-type 0110011 (f7 = 0000000 or 0100000): alu_fun = {f7[5],f3}, rf_wr_sel=3, regWrite=1.
  - OP-IMM 0010011: srcB=1. alu_fun = {f7[5],f3} when f3=101, else {0,f3}.
  - LOAD 0000011: srcB=1, memRead2=1, rf_wr_sel=2, regWrite=1.
  - STORE 0100011: srcB=2, memWrite=1.
  - LUI 0110111: srcA=1, alu_fun=1001, rf_wr_sel=3, regWrite=1.
  - AUIPC 0010111: srcA=1, srcB=3, alu_fun=0000, rf_wr_sel=3, regWrite=1.
  - JAL 1101111 and JALR 1100111: regWrite=1, rf_wr_sel=0.
  - BRANCH 1100011: all enables 0.
  - SYSTEM 1110011:
    - f3=000 → mret_exec=1.
    - f3=001 → csr_WE=1, regWrite=1, rf_wr_sel=1, alu_fun=1001.
    - f3=010 → same as 001, plus srcB=4, alu_fun=0110.
    - f3=011 → same as 010, plus srcA=2, alu_fun=0111.
- Decode table, M-ext: opcode 0110011 with f7=0000001 → mdu_sel=1, mdu_op=f3, rf_wr_sel=3, regWrite=1.
- Illegal: any other opcode, any other f7 on R-type, and SYSTEM f3 ∉ {000..011}. Sets illegal=1 with all write/exec enables 0. An illegal instruction still passes through the handshake normally.
- Handshake:
  - in_ready = (state==RUN) && (!out_valid || out_ready) && !flush.
  - Accept happens when in_valid && in_ready. The bundle is registered and out_valid=1 on the next edge (latency 1).
  - When out_valid && out_ready with no new accept, out_valid drops to 0.
  - out_valid and the bundle are stable while out_valid && !out_ready.
- FSM:
  - RUN → MDU_BUSY on accepting an M-op. That edge registers the bundle, pulses mdu_start, and loads cnt = LAT-1, where LAT = DIV_LAT if f3[2]=1, else MUL_LAT.
  - out_valid stays 0 in MDU_BUSY.
  - In MDU_BUSY, cnt decrements each cycle. When cnt==0: out_valid←1 and state←RUN.
  - With LAT=1, out_valid rises on the cycle after mdu_start, which is the same as a base op plus one cycle.
- flush (highest priority below reset):
  - On the next edge: out_valid←0, state←RUN, cnt←0.
  - If state was MDU_BUSY, mdu_abort pulses for one cycle.
  - No accept happens in the flush cycle.
- Simultaneous flush and cnt==0: flush wins; the bundle is never presented.

Optional Feature:
- Macro: OTTER_MEXT_EN.
- Defined: M-ext decode, the MDU_BUSY state, the counter, and mdu_* ports are active as described.
- Undefined:
  - f7=0000001 R-type decodes as illegal.
  - The FSM is always RUN.
  - mdu_sel, mdu_op, mdu_start and mdu_abort are tied to 0.
  - MUL_LAT and DIV_LAT are ignored.

Test Plan:
- Reset in MDU_BUSY: assert RST mid-wait → all outputs 0 immediately; in_ready=1 after release.
- add x3,x1,x2 (0x002081B3), out_ready=1 → next cycle out_valid=1, alu_fun=0000, rf_wr_sel=3, regWrite=1. Then sub (0x402081B3) on the following cycle → alu_fun=1000, back-to-back with no bubble.
- div x3,x1,x2 (0x0220C1B3), DIV_LAT=34 → mdu_start one cycle, in_ready=0; out_valid rises exactly 34 cycles after accept with mdu_sel=1, mdu_op=100. mul (0x022081B3) → same, after 2 cycles.
- Backpressure: out_ready=0 with out_valid=1, in_valid=1 → in_ready=0 and the bundle stays stable 5 cycles. Raise out_ready → the held bundle drains and the next instruction is accepted in the same cycle.
- flush on cycle 10 of a DIV → mdu_abort=1 next cycle, out_valid never rises, state RUN. Also flush coinciding with cnt==0 → no out_valid.
- Illegal/CSR: opcode 1111111 → illegal=1 with all enables 0. CSRRC (opcode 1110011, f3=011) → csr_WE=1, srcA=2, srcB=4, alu_fun=0111, rf_wr_sel=1. With OTTER_MEXT_EN undefined, 0x022081B3 → illegal=1.
